// File: rtl/regfile_write_arbiter.sv
// Write-side scheduler for the register file: two per-requester FIFOs, a
// round-robin arbiter feeding one registered RAM write port, and pending-write lookup.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_pending_a,
    output logic                  rd_pending_b,
    output logic                  idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_t;

    logic [1:0]            in_valid;
    addr_t                 in_addr   [2];
    data_t                 in_data   [2];
    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            push;
    logic [1:0]            pop;
    addr_t                 head_addr [2];
    data_t                 head_data [2];
    logic [FIFO_DEPTH-1:0] hit_a     [2];
    logic [FIFO_DEPTH-1:0] hit_b     [2];

    logic grant_any;
    req_t grant_sel;
    req_t last;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    // Ready depends only on rst and the registered count, never on valid.
    assign req0_ready = !rst && !full[0];
    assign req1_ready = !rst && !full[1];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [CNT_W-1:0]      count;
        logic [PTR_W-1:0]      wp;
        logic [PTR_W-1:0]      rp;
        logic [FIFO_DEPTH-1:0] occ;
        addr_t                 mem_addr [FIFO_DEPTH];
        data_t                 mem_data [FIFO_DEPTH];

        assign full[g]      = (count == CNT_W'(FIFO_DEPTH));
        assign empty[g]     = (count == '0);
        // Writes to register 0 are acknowledged but never enter the FIFO.
        assign push[g]      = in_valid[g] && !rst && !full[g] && (in_addr[g] != '0);
        assign head_addr[g] = mem_addr[rp];
        assign head_data[g] = mem_data[rp];

        always_ff @(posedge clk) begin
            if (rst) begin
                count <= '0;
                wp    <= '0;
                rp    <= '0;
                occ   <= '0;
            end else begin
                if (pop[g]) begin
                    rp      <= rp + PTR_W'(1);
                    occ[rp] <= 1'b0;
                end
                if (push[g]) begin
                    wp      <= wp + PTR_W'(1);
                    occ[wp] <= 1'b1;
                end
                count <= count + CNT_W'(push[g]) - CNT_W'(pop[g]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_addr[wp] <= in_addr[g];
                mem_data[wp] <= in_data[g];
            end
        end

        for (genvar s = 0; s < FIFO_DEPTH; s++) begin : g_slot
            assign hit_a[g][s] = occ[s] && (mem_addr[s] == rd_addr_a);
            assign hit_b[g][s] = occ[s] && (mem_addr[s] == rd_addr_b);
        end
    end

    always_comb begin
        grant_any = !empty[0] || !empty[1];
        grant_sel = REQ0;
        if (!empty[0] && !empty[1]) begin
            grant_sel = (last == REQ0) ? REQ1 : REQ0;
        end else if (!empty[1]) begin
            grant_sel = REQ1;
        end
    end

    assign pop[0] = grant_any && (grant_sel == REQ0);
    assign pop[1] = grant_any && (grant_sel == REQ1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last    <= REQ1;
        end else if (grant_any) begin
            wr_en   <= 1'b1;
            wr_addr <= (grant_sel == REQ1) ? head_addr[1] : head_addr[0];
            wr_data <= (grant_sel == REQ1) ? head_data[1] : head_data[0];
            last    <= grant_sel;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // The issued write stays pending until the RAM's write edge at the end of this cycle.
    assign rd_pending_a = (rd_addr_a != '0) &&
                          ((|hit_a[0]) || (|hit_a[1]) || (wr_en && (wr_addr == rd_addr_a)));
    assign rd_pending_b = (rd_addr_b != '0) &&
                          ((|hit_b[0]) || (|hit_b[1]) || (wr_en && (wr_addr == rd_addr_b)));

    assign idle = empty[0] && empty[1] && !wr_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus
// streaming sequences for contention and backpressure.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_addr;
    logic [31:0] req1_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr_a;
    logic [7:0]  rd_addr_b;
    logic        rd_pending_a;
    logic        rd_pending_b;
    logic        idle;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    regfile_write_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_pending_a(rd_pending_a), .rd_pending_b(rd_pending_b),
        .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        v0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        r0;
        logic        r1;
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        pa;
        logic        pb;
        logic        idl;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Streams n0/n1 writes (addr = base+i, data = D000_0000|addr) holding valid until accepted.
    task automatic run_stream(input int ncyc, input int s0, input int n0, input int b0,
                              input int s1, input int n1, input int b1,
                              input logic [31:0] er0, input logic [31:0] er1, input logic [31:0] ewe);
        int i0 = 0;
        int i1 = 0;
        logic [7:0] ea;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req0_valid = (c >= s0) && (i0 < n0);
            req0_addr  = 8'(b0 + i0);
            req0_data  = 32'hD000_0000 | 32'(b0 + i0);
            req1_valid = (c >= s1) && (i1 < n1);
            req1_addr  = 8'(b1 + i1);
            req1_data  = 32'hD000_0000 | 32'(b1 + i1);
            #1;
            if (req0_valid) chk("stream_ready0", c, 32'(req0_ready), 32'(er0[c]));
            if (req1_valid) chk("stream_ready1", c, 32'(req1_ready), 32'(er1[c]));
            chk("stream_wr_en", c, 32'(wr_en), 32'(ewe[c]));
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra @%0d: got write addr %0d expected none", c, wr_addr);
                end else begin
                    ea = exp_q.pop_front();
                    chk("stream_wr_addr", c, 32'(wr_addr), 32'(ea));
                    chk("stream_wr_data", c, wr_data, 32'hD000_0000 | 32'(ea));
                end
            end
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("stream_leftover", 0, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;

        //          rst  v0 a0     d0             v1 a1     d1          ra     rb       r0 r1 we wa     wd             pa pb idle
        vecs[0]  = '{1'b1, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd5,  8'd0,    0, 0, 0, 8'd0,  32'h0,         0, 0, 1};
        vecs[1]  = '{1'b0, 1, 8'd5,  32'hDEADBEEF, 0, 8'd0,  32'h0,      8'd5,  8'd0,    1, 1, 0, 8'd0,  32'h0,         0, 0, 1};
        vecs[2]  = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd5,  8'd0,    1, 1, 0, 8'd0,  32'h0,         1, 0, 0};
        vecs[3]  = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd5,  8'd0,    1, 1, 1, 8'd5,  32'hDEADBEEF,  1, 0, 0};
        vecs[4]  = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd5,  8'd0,    1, 1, 0, 8'd5,  32'hDEADBEEF,  0, 0, 1};
        vecs[5]  = '{1'b0, 0, 8'd0,  32'h0,        1, 8'd0,  32'h1234,   8'd5,  8'd0,    1, 1, 0, 8'd5,  32'hDEADBEEF,  0, 0, 1};
        vecs[6]  = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd0,  8'd0,    1, 1, 0, 8'd5,  32'hDEADBEEF,  0, 0, 1};
        vecs[7]  = '{1'b0, 1, 8'd7,  32'hA,        0, 8'd0,  32'h0,      8'd7,  8'd0,    1, 1, 0, 8'd5,  32'hDEADBEEF,  0, 0, 1};
        vecs[8]  = '{1'b0, 0, 8'd0,  32'h0,        1, 8'd7,  32'hB,      8'd7,  8'd0,    1, 1, 0, 8'd5,  32'hDEADBEEF,  1, 0, 0};
        vecs[9]  = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd7,  8'd0,    1, 1, 1, 8'd7,  32'hA,         1, 0, 0};
        vecs[10] = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd7,  8'd0,    1, 1, 1, 8'd7,  32'hB,         1, 0, 0};
        vecs[11] = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd7,  8'd0,    1, 1, 0, 8'd7,  32'hB,         0, 0, 1};
        vecs[12] = '{1'b0, 1, 8'd20, 32'h20,       1, 8'd30, 32'h30,     8'd21, 8'd31,   1, 1, 0, 8'd7,  32'hB,         0, 0, 1};
        vecs[13] = '{1'b0, 1, 8'd21, 32'h21,       1, 8'd31, 32'h31,     8'd21, 8'd31,   1, 1, 0, 8'd7,  32'hB,         0, 0, 0};
        vecs[14] = '{1'b1, 1, 8'd22, 32'h22,       0, 8'd0,  32'h0,      8'd21, 8'd31,   0, 0, 1, 8'd20, 32'h20,        1, 1, 0};
        vecs[15] = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd21, 8'd31,   1, 1, 0, 8'd0,  32'h0,         0, 0, 1};
        vecs[16] = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd20, 8'd30,   1, 1, 0, 8'd0,  32'h0,         0, 0, 1};
        vecs[17] = '{1'b0, 0, 8'd0,  32'h0,        0, 8'd0,  32'h0,      8'd21, 8'd31,   1, 1, 0, 8'd0,  32'h0,         0, 0, 1};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req0_addr  = vecs[i].a0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_addr  = vecs[i].a1;
            req1_data  = vecs[i].d1;
            rd_addr_a  = vecs[i].ra;
            rd_addr_b  = vecs[i].rb;
            #1;
            chk("req0_ready",   i, 32'(req0_ready),   32'(vecs[i].r0));
            chk("req1_ready",   i, 32'(req1_ready),   32'(vecs[i].r1));
            chk("wr_en",        i, 32'(wr_en),        32'(vecs[i].we));
            chk("wr_addr",      i, 32'(wr_addr),      32'(vecs[i].wa));
            chk("wr_data",      i, wr_data,           vecs[i].wd);
            chk("rd_pending_a", i, 32'(rd_pending_a), 32'(vecs[i].pa));
            chk("rd_pending_b", i, 32'(rd_pending_b), 32'(vecs[i].pb));
            chk("idle",         i, 32'(idle),         32'(vecs[i].idl));
        end
        rd_addr_a = '0;
        rd_addr_b = '0;

        // Contention right after reset: req0 must win first, strict alternation.
        exp_q = '{8'd1, 8'd11, 8'd2, 8'd12, 8'd3, 8'd13, 8'd4, 8'd14};
        run_stream(11, 0, 4, 1, 0, 4, 11, 32'b10111, 32'b101011, 32'b01111111100);

        // req1 streams; req0 joins late and is held off while its FIFO is full.
        exp_q = '{8'd40, 8'd41, 8'd50, 8'd42, 8'd51, 8'd43, 8'd52, 8'd44, 8'd53, 8'd45};
        run_stream(13, 2, 4, 50, 0, 6, 40, 32'b1011100, 32'b10101111, 32'b0111111111100);

        #1;
        chk("final_idle", 0, 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
